// File: rtl/fe_pkg.sv
// fe_pkg: shared defaults and helpers for the parametrised fetch stage
package fe_pkg;
  localparam int INSTR_W_D   = 16;
  localparam int ADDR_W_D    = 16;
  localparam int RESET_PC_D  = 8;
  localparam int NOP_INSTR_D = 0;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 1; i < n; i = i * 2) r++;
    return r;
  endfunction
endpackage

// File: rtl/fe_imem.sv
// fe_imem: synchronous-read instruction ROM with read enable and resettable output register
module fe_imem #(
  parameter int INSTR_W = 16,
  parameter int MEM_DEPTH = 128,
  parameter INIT_FILE = "test1.mif",
  parameter logic [INSTR_W-1:0] NOP = '0,
  parameter int IW = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               re,
  input  logic [IW-1:0]      addr,
  output logic [INSTR_W-1:0] rdata_q
);
  (* ram_init_file = INIT_FILE *) logic [INSTR_W-1:0] rom [MEM_DEPTH];
  logic [INSTR_W-1:0] rdata_d;
  always_comb rdata_d = rst ? NOP : re ? rom[addr] : rdata_q;
  always_ff @(posedge clk) rdata_q <= rdata_d;
endmodule

// File: rtl/fetch_stage_p.sv
// fetch_stage_p: PC register, synchronous imem read stage and FE/ID latch with valid,
// branch flush (two-bubble penalty) and full-stage stall
module fetch_stage_p
  import fe_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int MEM_DEPTH = 128,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_D),
  parameter int PC_INC = 1,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_D),
  parameter INIT_FILE = "test1.mif"
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               BRANCH,
  input  logic               STALL,
  input  logic [ADDR_W-1:0]  branch_instr_addr,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_instr_addr,
  output logic               id_valid,
  output logic [ADDR_W-1:0]  fe_pc
);
  localparam int IW = clog2(MEM_DEPTH) < 1 ? 1 : clog2(MEM_DEPTH);
  logic [ADDR_W-1:0]  pc_q, pc_d, mem_addr_q, mem_addr_d, id_addr_q, id_addr_d;
  logic [INSTR_W-1:0] mem_q, id_instr_q, id_instr_d;
  logic               mem_vld_q, mem_vld_d, id_vld_q, id_vld_d, adv, kill;
  assign adv  = !BRANCH && !STALL;
  assign kill = reset || BRANCH;
  // MEM_DEPTH is a power of two, so the low pc bits are the modulo index
  fe_imem #(
    .INSTR_W(INSTR_W), .MEM_DEPTH(MEM_DEPTH), .INIT_FILE(INIT_FILE), .NOP(NOP_INSTR), .IW(IW)
  ) u_imem (
    .clk(CLOCK_50), .rst(reset), .re(adv), .addr(pc_q[IW-1:0]), .rdata_q(mem_q)
  );
  always_comb begin
    pc_d       = reset ? RESET_PC : BRANCH ? branch_instr_addr : STALL ? pc_q : pc_q + ADDR_W'(PC_INC);
    mem_addr_d = reset ? '0 : adv ? pc_q : mem_addr_q;
    mem_vld_d  = kill ? 1'b0 : STALL ? mem_vld_q : 1'b1;
    id_vld_d   = kill ? 1'b0 : STALL ? id_vld_q : mem_vld_q;
    id_addr_d  = kill ? '0 : STALL ? id_addr_q : mem_vld_q ? mem_addr_q : '0;
    id_instr_d = kill ? NOP_INSTR : STALL ? id_instr_q : mem_vld_q ? mem_q : NOP_INSTR;
  end
  always_ff @(posedge CLOCK_50) begin
    pc_q       <= pc_d;
    mem_addr_q <= mem_addr_d;
    mem_vld_q  <= mem_vld_d;
    id_vld_q   <= id_vld_d;
    id_addr_q  <= id_addr_d;
    id_instr_q <= id_instr_d;
  end
  assign id_instr      = id_instr_q;
  assign id_instr_addr = id_addr_q;
  assign id_valid      = id_vld_q;
  assign fe_pc         = pc_q;
endmodule
